wide_add_sequencer: RTL

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

---
 rtl/wide_add_pkg.sv | 14 +
 rtl/cla_unit.sv | 45 ++++
 rtl/wide_add_sequencer_slice_adder.sv | 32 +++
 rtl/wide_add_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared constants and state type for the slice-serial wide adder.
// Defaults give a 64-bit add built from four 16-bit passes.
package wide_add_pkg;

    localparam int DEF_N_SLICE = 16;
    localparam int DEF_WORDS   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_unit.sv
// Parallel-prefix carry lookahead: turns per-bit propagate/generate plus a
// carry-in into every internal carry, c_o[i] being the carry into bit i.
module cla_unit #(
    parameter int N = 16
) (
    input  logic [N-1:0] p_i,
    input  logic [N-1:0] g_i,
    input  logic         c_i,
    output logic [N:0]   c_o
);

    localparam int LEVELS = (N > 1) ? $clog2(N) : 0;

    logic [LEVELS:0][N-1:0] gs;
    logic [LEVELS:0][N-1:0] ps;

    // Kogge-Stone style: at level l each bit merges the group 2^(l-1) below it,
    // so after LEVELS steps gs/ps cover the whole span down to bit 0.
    always_comb begin
        gs    = '0;
        ps    = '0;
        gs[0] = g_i;
        ps[0] = p_i;
        for (int l = 1; l <= LEVELS; l++) begin
            for (int i = 0; i < N; i++) begin
                if (i >= (1 << (l - 1))) begin
                    gs[l][i] = gs[l-1][i] | (ps[l-1][i] & gs[l-1][i - (1 << (l - 1))]);
                    ps[l][i] = ps[l-1][i] & ps[l-1][i - (1 << (l - 1))];
                end else begin
                    gs[l][i] = gs[l-1][i];
                    ps[l][i] = ps[l-1][i];
                end
            end
        end
    end

    always_comb begin
        c_o    = '0;
        c_o[0] = c_i;
        for (int i = 0; i < N; i++) begin
            c_o[i+1] = gs[LEVELS][i] | (ps[LEVELS][i] & c_i);
        end
    end

endmodule

// File: rtl/wide_add_sequencer_slice_adder.sv
// One N-bit adder slice: sum and carry-out via the lookahead unit, plus the
// carry into the top bit so the caller can derive signed overflow.
module slice_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);

    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N:0]   c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    cla_unit #(.N(N)) u_cla (
        .p_i (p),
        .g_i (g),
        .c_i (cin_i),
        .c_o (c)
    );

    assign sum_o  = p ^ c[N-1:0];
    assign cout_o = c[N];
    assign cmsb_o = c[N-1];

endmodule

// File: rtl/wide_add_sequencer.sv
// W-bit add/subtract computed one N_SLICE-bit slice per cycle through a single
// shared slice adder, with a valid/ready handshake on both sides.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int N_SLICE = DEF_N_SLICE,
    parameter int WORDS   = DEF_WORDS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_SLICE*WORDS-1:0]   a,
    input  logic [N_SLICE*WORDS-1:0]   b,
    input  logic                       cin,
    input  logic                       op_sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_SLICE*WORDS-1:0]   sum,
    output logic                       cout,
    output logic                       overflow
);

    localparam int W     = N_SLICE * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [N_SLICE-1:0] slice_a;
    logic [N_SLICE-1:0] slice_b;
    logic [N_SLICE-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_cmsb;

    assign slice_a = a_q[idx_q*N_SLICE +: N_SLICE];
    assign slice_b = b_q[idx_q*N_SLICE +: N_SLICE];

    slice_adder #(.N(N_SLICE)) u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout),
        .cmsb_o (slice_cmsb)
    );

    // Operands are captured at accept with B already inverted for subtract, so
    // the CALC loop is a plain add and later input changes cannot leak in.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub | cin;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[idx_q*N_SLICE +: N_SLICE] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
